pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch-stage program-counter controller for the pipelined MIPS core. Owns the PC register and drives the PC+4 incrementor. Selects the next PC from four sources: sequential, branch, jump and exception vector. Sequences fetch requests to instruction memory under hazard stalls and memory back-pressure, and emits a one-cycle flush toward IF/ID on every redirect.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC loaded when an exception is taken

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  hazard-unit stall; hold PC, no new fetch
br_taken_i  input  1  resolved branch taken (EX stage), single-cycle pulse
br_target_i  input  32  branch target address
jmp_i  input  1  jump decoded (ID stage), single-cycle pulse
jmp_target_i  input  32  jump target address
exc_i  input  1  exception request, single-cycle pulse
imem_ready_i  input  1  instruction memory accepts the fetch this cycle
fetch_valid_o  output  1  fetch request valid for pc_o
pc_o  output  32  current fetch PC
pc_plus4_o  output  32  pc_o + 4 (incrementor output, registered copy)
flush_o  output  1  squash IF/ID contents, one-cycle pulse
misalign_o  output  1  sticky misaligned-target flag (optional feature only; else tied 0)

Behaviour:
- FSM states: BOOT, RUN, HOLD, REDIRECT.
- Reset (rst=1 at a rising edge) puts the block in BOOT on that edge, with:
  - pc_o=RESET_VECTOR, pc_plus4_o=RESET_VECTOR+4
  - fetch_valid_o=0, flush_o=0, misalign_o=0
- Reset overrides everything, including a pending redirect or HOLD.
- BOOT: fetch_valid_o=0 for exactly one cycle, then RUN.
- RUN: fetch_valid_o=1.
  - Fetch accepted when fetch_valid_o && imem_ready_i && !stall_i; then pc_o <= pc_plus4_o.
  - imem_ready_i=0 or stall_i=1 -> HOLD, with pc_o unchanged.
- HOLD: fetch_valid_o=1 and pc_o held. Return to RUN and advance on the first cycle where imem_ready_i=1 && !stall_i, which is an accepted fetch.
- Redirect priority: exc_i > br_taken_i > jmp_i.
  - Applies in RUN, HOLD and REDIRECT, and overrides stall_i and imem_ready_i.
  - Next edge: pc_o <= selected target (EXC_VECTOR, br_target_i or jmp_target_i), and the state goes to REDIRECT.
  - Same-cycle lower-priority requests are dropped.
- REDIRECT: flush_o=1 and fetch_valid_o=0 for exactly one cycle, then RUN.
  - A new redirect arriving in REDIRECT restarts REDIRECT with the new target, so flush_o stays high one more cycle.
- Redirects in BOOT are ignored.
- pc_plus4_o always equals pc_o + 32'h4 modulo 2^32, registered alongside pc_o, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Latency:
  - Accepted fetch to new pc_o: 1 cycle.
  - Redirect input to target on pc_o: 1 cycle.
  - Target on pc_o to fetch_valid_o=1: 1 further cycle.
- flush_o is 0 in every state except REDIRECT.
- Targets are taken as given; bits [1:0] are not forced to zero.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect target with bits [1:0] != 0 is replaced by EXC_VECTOR (same REDIRECT sequencing).
  - misalign_o sets on that edge and stays 1 until rst.
  - exc_i redirects are not checked.
- Undefined: targets are loaded unmodified, and misalign_o is constant 0.

Test Plan:
1. rst high 3 cycles, then low; imem_ready_i=1 -> pc_o=0 with fetch_valid_o=0 for 1 cycle, then 0,4,8,12 on successive cycles.
2. At pc_o=8: stall_i high 2 cycles, then imem_ready_i low 1 cycle -> pc_o holds 8 with fetch_valid_o=1 for 3 cycles, then 12.
3. br_taken_i and jmp_i both pulsed, br_target_i=0x100, jmp_target_i=0x200, stall_i=1 -> next cycle pc_o=0x100 and flush_o=1, fetch_valid_o=0; following cycle fetch_valid_o=1 and pc_o=0x100.
4. exc_i with br_taken_i in the same cycle -> pc_o=0x80; a branch to 0x300 in the REDIRECT cycle -> pc_o=0x300 and flush_o high 2 consecutive cycles.
5. Jump to 0xFFFF_FFFC -> after one accepted fetch, pc_o=0x0000_0000 and pc_plus4_o=0x4; rst asserted during REDIRECT -> pc_o=RESET_VECTOR and flush_o=0 the next cycle.
6. With PC_ALIGN_CHECK_EN: jmp_target_i=0x102 -> pc_o=0x80 and misalign_o=1, sticky until rst. Without the macro -> pc_o=0x102 and misalign_o=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: redirect requests, hazard/back-pressure inputs
// and the fetch request outputs. master = sequencer side, slave = pipeline side.
interface pc_sequencer_if;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic        exc_i;
  logic        imem_ready_i;
  logic        fetch_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        flush_o;
  logic        misalign_o;

  modport master (
    input  stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, exc_i,
           imem_ready_i,
    output fetch_valid_o, pc_o, pc_plus4_o, flush_o, misalign_o
  );

  modport slave (
    output stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, exc_i,
           imem_ready_i,
    input  fetch_valid_o, pc_o, pc_plus4_o, flush_o, misalign_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: PC register, registered PC+4, redirect/stall sequencing.
// Optional macro PC_ALIGN_CHECK_EN: misaligned branch/jump targets trap to EXC_VECTOR.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_plus4, pc_nxt;
  logic        redirect, take_redirect, target_bad;
  logic [31:0] raw_target, redirect_target;

  // Priority exc > branch > jump; lower-priority requests are simply dropped.
  always_comb begin
    redirect   = bus.exc_i | bus.br_taken_i | bus.jmp_i;
    raw_target = bus.jmp_target_i;
    if (bus.exc_i)           raw_target = EXC_VECTOR;
    else if (bus.br_taken_i) raw_target = bus.br_target_i;
`ifdef PC_ALIGN_CHECK_EN
    target_bad = !bus.exc_i && (raw_target[1:0] != 2'b00);
`else
    target_bad = 1'b0;
`endif
    redirect_target = target_bad ? EXC_VECTOR : raw_target;
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    take_redirect = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, HOLD: begin
        if (redirect) begin
          take_redirect = 1'b1;
        end else if (bus.imem_ready_i && !bus.stall_i) begin
          state_nxt = RUN;
          pc_nxt    = pc_plus4;
        end else begin
          state_nxt = HOLD;
        end
      end
      REDIRECT: begin
        if (redirect) take_redirect = 1'b1;
        else          state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
    if (take_redirect) begin
      state_nxt = REDIRECT;
      pc_nxt    = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      pc_plus4 <= RESET_VECTOR + 32'd4;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_plus4 <= pc_nxt + 32'd4;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign;

  always_ff @(posedge clk) begin
    if (rst)                              misalign <= 1'b0;
    else if (take_redirect && target_bad) misalign <= 1'b1;
  end

  assign bus.misalign_o = misalign;
`else
  assign bus.misalign_o = 1'b0;
`endif

  assign bus.pc_o          = pc;
  assign bus.pc_plus4_o    = pc_plus4;
  assign bus.fetch_valid_o = (state == RUN) || (state == HOLD);
  assign bus.flush_o       = (state == REDIRECT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the fetch PC.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h0000_0080;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fv;
    logic        fl;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q[$];

  // Model state: PC value plus "booting"/"flushing" flags.
  logic [31:0] m_pc   = RV;
  logic        m_boot = 1'b1;
  logic        m_fl   = 1'b0;
  logic        m_mis  = 1'b0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a fetch-stage state; compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_o", bus.pc_o, e.pc);
        chk("pc_plus4_o", bus.pc_plus4_o, e.pc4);
        chk("fetch_valid_o", {31'd0, bus.fetch_valid_o}, {31'd0, e.fv});
        chk("flush_o", {31'd0, bus.flush_o}, {31'd0, e.fl});
        chk("misalign_o", {31'd0, bus.misalign_o}, {31'd0, e.mis});
      end
    end
  end

  // Behavioural rule set applied at each edge; pushes the post-edge outputs.
  task automatic model_step(input logic r, input logic st, input logic br,
                            input logic [31:0] bt, input logic jp,
                            input logic [31:0] jt, input logic ex,
                            input logic rdy);
    exp_t e;
    logic [31:0] tgt;
    logic fetching;
    fetching = !m_boot && !m_fl;
    if (r) begin
      m_pc = RV; m_boot = 1'b1; m_fl = 1'b0; m_mis = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (ex || br || jp) begin
      tgt = ex ? EXC : (br ? bt : jt);
`ifdef PC_ALIGN_CHECK_EN
      if (!ex && (tgt % 4 != 0)) begin
        tgt = EXC;
        m_mis = 1'b1;
      end
`endif
      m_pc = tgt;
      m_fl = 1'b1;
    end else begin
      if (fetching && rdy && !st) m_pc = m_pc + 32'd4;
      m_fl = 1'b0;
    end
    e.pc  = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.fv  = !m_boot && !m_fl;
    e.fl  = m_fl;
    e.mis = m_mis;
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic st, input logic br,
                     input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                     input logic ex, input logic rdy);
    rst              = r;
    bus.stall_i      = st;
    bus.br_taken_i   = br;
    bus.br_target_i  = bt;
    bus.jmp_i        = jp;
    bus.jmp_target_i = jt;
    bus.exc_i        = ex;
    bus.imem_ready_i = rdy;
    model_step(r, st, br, bt, jp, jt, ex, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, '0, 0, 1);
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFC;
    if (sel == 1) return $urandom();
    return {$urandom_range(0, 32'h0000_FFFF), 2'b00};
  endfunction

  initial begin
    for (int unsigned i = 0; i < 3; i++) cyc(1, 0, 0, '0, 0, '0, 0, 1);
    idle(3);
    cyc(0, 1, 0, '0, 0, '0, 0, 1);
    cyc(0, 1, 0, '0, 0, '0, 0, 1);
    cyc(0, 0, 0, '0, 0, '0, 0, 0);
    idle(2);
    cyc(0, 1, 1, 32'h100, 1, 32'h200, 0, 1);
    idle(2);
    cyc(0, 0, 1, 32'h400, 0, '0, 1, 1);
    cyc(0, 0, 1, 32'h300, 0, '0, 0, 1);
    idle(2);
    cyc(0, 0, 0, '0, 1, 32'hFFFF_FFFC, 0, 1);
    idle(3);
    cyc(0, 0, 0, '0, 1, 32'h40, 0, 1);
    cyc(1, 0, 0, '0, 0, '0, 0, 1);
    idle(2);
    cyc(0, 0, 0, '0, 1, 32'h102, 0, 1);
    idle(3);
    cyc(0, 0, 1, 32'h203, 0, '0, 0, 1);
    idle(2);
    cyc(1, 0, 0, '0, 0, '0, 0, 1);
    idle(2);

    for (int unsigned i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, rand_target(),
          $urandom_range(0, 9) == 0, rand_target(),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0);
    end
    idle(2);

    for (int unsigned i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
